// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue: decouples instruction memory from decode.
// Issues up to MAX_OUTSTANDING in-order fetch requests, tags each with its PC,
// and buffers responses in a QUEUE_DEPTH-entry instruction queue.
// A redirect flushes the queue and marks every in-flight request for drop.
// Optional macro FETCH_PERF_EN adds perf_issued_o / perf_delivered_o /
// perf_flushed_o event counters.
module fetch_prefetch_queue #(
    parameter int              XLEN            = 32,
    parameter logic [XLEN-1:0] RESET_PC        = 'h8000_0000,
    parameter int              QUEUE_DEPTH     = 4,
    parameter int              MAX_OUTSTANDING = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic            mem_req_valid_o,
    input  logic            mem_req_ready_i,
    output logic [XLEN-1:0] mem_req_addr_o,
    input  logic            mem_resp_valid_i,
    input  logic [31:0]     mem_resp_data_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            dec_valid_o,
    input  logic            dec_ready_i,
    output logic [31:0]     dec_instr_o,
    output logic [XLEN-1:0] dec_pc_o,
    output logic            fetch_busy_o
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_issued_o,
    output logic [31:0]     perf_delivered_o,
    output logic [31:0]     perf_flushed_o
`endif
);

    localparam int QAW = $clog2(QUEUE_DEPTH);
    localparam int OCW = $clog2(QUEUE_DEPTH + 1);
    localparam int OSW = $clog2(MAX_OUTSTANDING + 1);
    localparam int TAW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW  = OCW + 2;

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_tag [MAX_OUTSTANDING];
    logic [TAW-1:0]  r_tag_wp, r_tag_rp;
    logic [XLEN-1:0] r_q_pc    [QUEUE_DEPTH];
    logic [31:0]     r_q_instr [QUEUE_DEPTH];
    logic [QAW-1:0]  r_q_wp, r_q_rp;
    logic [OCW-1:0]  r_occ;
    logic [OSW-1:0]  r_outst;
    logic [OSW-1:0]  r_drop;

    logic [CW-1:0]   w_credit;
    logic            w_issue, w_req_acc, w_resp, w_resp_keep, w_resp_drop, w_pop;
    logic [OSW-1:0]  w_outst_nxt;

    // Tag FIFO depth need not be a power of two, so wrap explicitly.
    function automatic logic [TAW-1:0] tag_inc(input logic [TAW-1:0] p);
        return (p == TAW'(MAX_OUTSTANDING - 1)) ? '0 : p + TAW'(1);
    endfunction

    // Credits cover queued, in-flight and to-be-dropped slots so the queue cannot overflow.
    always_comb begin
        w_credit    = CW'(r_occ) + CW'(r_outst) + CW'(r_drop);
        w_issue     = rst_i && !redirect_valid_i &&
                      (r_outst < OSW'(MAX_OUTSTANDING)) &&
                      (w_credit < CW'(QUEUE_DEPTH));
        w_req_acc   = w_issue && mem_req_ready_i;
        w_resp      = mem_resp_valid_i && (r_outst != '0);
        w_resp_keep = w_resp && (r_drop == '0) && !redirect_valid_i;
        w_resp_drop = w_resp && !w_resp_keep;
        w_pop       = (r_occ != '0) && dec_ready_i && !redirect_valid_i;
        w_outst_nxt = r_outst + OSW'(w_req_acc) - OSW'(w_resp);
    end

    assign mem_req_valid_o = w_issue;
    assign mem_req_addr_o  = r_fetch_pc;
    assign dec_valid_o     = (r_occ != '0);
    assign dec_instr_o     = dec_valid_o ? r_q_instr[r_q_rp] : '0;
    assign dec_pc_o        = dec_valid_o ? r_q_pc[r_q_rp]    : '0;
    assign fetch_busy_o    = (r_outst != '0) || (r_occ != '0);

    // Control state: fetch PC, pointers, occupancy, outstanding and drop counters.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_fetch_pc <= RESET_PC;
            r_tag_wp   <= '0;
            r_tag_rp   <= '0;
            r_q_wp     <= '0;
            r_q_rp     <= '0;
            r_occ      <= '0;
            r_outst    <= '0;
            r_drop     <= '0;
        end else begin
            r_outst <= w_outst_nxt;
            if (w_req_acc) r_tag_wp <= tag_inc(r_tag_wp);
            if (w_resp)    r_tag_rp <= tag_inc(r_tag_rp);
            if (redirect_valid_i) begin
                // Flush wins over decode pop; everything still in flight is dropped.
                r_fetch_pc <= redirect_pc_i;
                r_q_wp     <= '0;
                r_q_rp     <= '0;
                r_occ      <= '0;
                r_drop     <= w_outst_nxt;
            end else begin
                if (w_req_acc)   r_fetch_pc <= r_fetch_pc + XLEN'(4);
                if (w_resp_keep) r_q_wp <= r_q_wp + QAW'(1);
                if (w_pop)       r_q_rp <= r_q_rp + QAW'(1);
                r_occ <= r_occ + OCW'(w_resp_keep) - OCW'(w_pop);
                if (w_resp_drop) r_drop <= r_drop - OSW'(1);
            end
        end
    end

    // Storage: PC tags of issued requests and queued {PC, instruction} pairs.
    always_ff @(posedge clk_i) begin
        if (w_req_acc)   r_tag[r_tag_wp] <= r_fetch_pc;
        if (w_resp_keep) begin
            r_q_pc[r_q_wp]    <= r_tag[r_tag_rp];
            r_q_instr[r_q_wp] <= mem_resp_data_i;
        end
    end

`ifdef FETCH_PERF_EN
    // Event counters: accepted requests, decode pops, discarded entries/responses.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            perf_issued_o    <= '0;
            perf_delivered_o <= '0;
            perf_flushed_o   <= '0;
        end else begin
            perf_issued_o    <= perf_issued_o + 32'(w_req_acc);
            perf_delivered_o <= perf_delivered_o + 32'(w_pop);
            perf_flushed_o   <= perf_flushed_o +
                                (redirect_valid_i ? 32'(r_occ) : 32'd0) +
                                32'(w_resp_drop);
        end
    end
`endif

`ifndef SYNTHESIS
    // A response with nothing outstanding is a memory protocol error.
    always_ff @(posedge clk_i) begin
        if (rst_i && mem_resp_valid_i)
            assert (r_outst != '0) else $error("response with no outstanding request");
    end
`endif

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Self-checking bench for fetch_prefetch_queue: directed steps followed by a
// randomized run, all checked against a queue-based reference model.
module tb_fetch_prefetch_queue;

    localparam int          QD   = 4;
    localparam int          MO   = 2;
    localparam logic [31:0] RPC  = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        mem_req_valid_o, mem_req_ready_i;
    logic [31:0] mem_req_addr_o;
    logic        mem_resp_valid_i;
    logic [31:0] mem_resp_data_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        dec_valid_o, dec_ready_i;
    logic [31:0] dec_instr_o, dec_pc_o;
    logic        fetch_busy_o;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_issued_o, perf_delivered_o, perf_flushed_o;
`endif

    always #5 clk = ~clk;

    fetch_prefetch_queue #(
        .XLEN(32), .RESET_PC(RPC), .QUEUE_DEPTH(QD), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_req_addr_o(mem_req_addr_o),
        .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_data_i(mem_resp_data_i),
        .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
        .dec_valid_o(dec_valid_o), .dec_ready_i(dec_ready_i),
        .dec_instr_o(dec_instr_o), .dec_pc_o(dec_pc_o),
        .fetch_busy_o(fetch_busy_o)
`ifdef FETCH_PERF_EN
        , .perf_issued_o(perf_issued_o), .perf_delivered_o(perf_delivered_o),
        .perf_flushed_o(perf_flushed_o)
`endif
    );

    int tests = 0;
    int fails = 0;

    // Reference model: fetch PC, decode queue, in-flight addresses, pending drops.
    logic [31:0] m_pc;
    logic [31:0] m_qpc[$];
    logic [31:0] m_qins[$];
    logic [31:0] p_addr[$];
    int          m_drop;
    int unsigned m_issued, m_deliv, m_flush;
    int          hs_cnt, pop_cnt;

    // Instruction word the mock memory returns for an address.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[7:0], a[31:24] ^ 8'h5A, a[15:8], a[23:16]} ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = RPC;
        m_qpc.delete(); m_qins.delete(); p_addr.delete();
        m_drop = 0; m_issued = 0; m_deliv = 0; m_flush = 0;
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        mem_req_ready_i = 0; mem_resp_valid_i = 0; mem_resp_data_i = '0;
        redirect_valid_i = 0; redirect_pc_i = '0; dec_ready_i = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk("rst_req_valid", 32'(mem_req_valid_o), 32'd0);
        chk("rst_addr", mem_req_addr_o, RPC);
        chk("rst_dec_valid", 32'(dec_valid_o), 32'd0);
        chk("rst_busy", 32'(fetch_busy_o), 32'd0);
        chk("rst_dec_pc", dec_pc_o, 32'd0);
`ifdef FETCH_PERF_EN
        chk("rst_perf_iss", perf_issued_o, 32'd0);
        chk("rst_perf_flush", perf_flushed_o, 32'd0);
`endif
        rst_i = 1'b1;
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, advance model.
    task automatic step(input bit rdy, input bit rwant, input bit redir,
                        input logic [31:0] rpc, input bit drdy);
        bit exp_v, acc, resp, pop;
        logic [31:0] a;
        mem_req_ready_i  = rdy;
        redirect_valid_i = redir;
        redirect_pc_i    = rpc;
        dec_ready_i      = drdy;
        resp             = rwant && (p_addr.size() > 0);
        mem_resp_valid_i = resp;
        mem_resp_data_i  = resp ? memf(p_addr[0]) : 32'h0;
        @(negedge clk);
        exp_v = !redir && (p_addr.size() < MO) &&
                ((m_qpc.size() + p_addr.size() + m_drop) < QD);
        chk("req_valid", 32'(mem_req_valid_o), 32'(exp_v));
        chk("req_addr", mem_req_addr_o, m_pc);
        chk("dec_valid", 32'(dec_valid_o), 32'(m_qpc.size() > 0));
        chk("busy", 32'(fetch_busy_o), 32'((m_qpc.size() > 0) || (p_addr.size() > 0)));
        if (m_qpc.size() > 0) begin
            chk("dec_pc", dec_pc_o, m_qpc[0]);
            chk("dec_instr", dec_instr_o, m_qins[0]);
        end
`ifdef FETCH_PERF_EN
        chk("perf_issued", perf_issued_o, m_issued);
        chk("perf_delivered", perf_delivered_o, m_deliv);
        chk("perf_flushed", perf_flushed_o, m_flush);
`endif
        if (mem_req_valid_o && rdy) hs_cnt++;
        acc = exp_v && rdy;
        pop = (m_qpc.size() > 0) && drdy && !redir;
        if (pop) pop_cnt++;
        if (resp) begin
            a = p_addr.pop_front();
            if (m_drop > 0 || redir) begin
                if (m_drop > 0) m_drop--;
                m_flush++;
            end else begin
                m_qpc.push_back(a);
                m_qins.push_back(memf(a));
            end
        end
        if (redir) begin
            m_flush += m_qpc.size();
            m_qpc.delete(); m_qins.delete();
            m_pc   = rpc;
            m_drop = p_addr.size();
        end else begin
            if (pop) begin
                void'(m_qpc.pop_front());
                void'(m_qins.pop_front());
                m_deliv++;
            end
            if (acc) begin
                p_addr.push_back(m_pc);
                m_pc += 32'd4;
                m_issued++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit found;
        logic [31:0] rp;

        // Streaming: one instruction per cycle once the pipe fills.
        do_reset();
        chk("first_addr", mem_req_addr_o, 32'h8000_0000);
        pop_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 10) pop_cnt = 0;
            step(1, 1, 0, '0, 1);
        end
        chk("sustained_pops", pop_cnt, 32'd10);

        // Decode stalled: exactly QUEUE_DEPTH requests accepted, then issue stops.
        do_reset();
        hs_cnt = 0;
        for (int i = 0; i < 10; i++) step(1, 1, 0, '0, 0);
        chk("fill_accepts", hs_cnt, QD);
        chk("fill_stalled", 32'(mem_req_valid_o), 32'd0);
        step(1, 1, 0, '0, 1);
        step(1, 1, 0, '0, 1);

        // Redirect with two in flight: both dropped, first delivery is the target.
        do_reset();
        step(1, 0, 0, '0, 0);
        step(1, 0, 0, '0, 0);
        step(1, 0, 1, 32'h8000_0100, 0);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1, 1, 0, '0, 0);
            if (dec_valid_o) begin
                found = 1;
                chk("redir_pc", dec_pc_o, 32'h8000_0100);
                chk("redir_instr", dec_instr_o, memf(32'h8000_0100));
            end
        end
        chk("redir_delivered", 32'(found), 32'd1);

        // Redirect coinciding with a response and a decode pop.
        do_reset();
        step(1, 0, 0, '0, 0);
        step(1, 0, 0, '0, 0);
        step(1, 1, 0, '0, 0);
        step(1, 1, 1, 32'h8000_0200, 1);
        chk("coinc_dec_valid", 32'(dec_valid_o), 32'd0);
        chk("coinc_addr", mem_req_addr_o, 32'h8000_0200);
        for (int i = 0; i < 6; i++) step(1, 1, 0, '0, 1);

        // Reset mid-stream with work queued and in flight.
        for (int i = 0; i < 5; i++) step(1, 1, 0, '0, 0);
        do_reset();

        // Ten deliveries then a redirect that flushes queued and in-flight work.
        for (int i = 0; i < 12; i++) step(1, 1, 0, '0, 1);
        for (int i = 0; i < 3; i++) step(1, 1, 0, '0, 0);
        step(1, 0, 1, 32'h8000_0400, 0);
        for (int i = 0; i < 6; i++) step(1, 1, 0, '0, 0);

        // Randomized traffic with occasional redirects and resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            rp = {$urandom(), 2'b00} >> 0;
            rp[1:0] = 2'b00;
            step($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 29) == 0, rp, $urandom_range(0, 9) < 7);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
